unpacker: RTL and testbench



---
 rtl/unpacker.sv | 178 +++++++++++++++++
 tb/tb_unpacker.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/unpacker.sv
// unpacker
// Read-side counterpart of the output packer. Accepts densely packed 64-bit
// words from the SRAM read port and re-emits them to a compute engine as
// beats of up to `lanes` bytes, each carrying a byte-valid mask and tlast.
// One transfer of `len` bytes runs per start pulse.
//
// Ports:
//   clk, rst        clock, synchronous active-low reset
//   start_i         one-cycle pulse that begins a transfer (ignored while busy)
//   len_i           transfer length in bytes, sampled on start_i
//   lanes_i         bytes per output beat, sampled on start_i (0 or >8 -> 8)
//   in_valid        data_i holds a packed word
//   in_ready        word is accepted this cycle
//   data_i          packed word, byte 0 in bits [7:0]
//   data_o          output beat, valid bytes from byte 0, unused bytes zero
//   valid_mask      per-byte valid bits of data_o
//   tlast_o         final beat of the transfer
//   out_valid       output beat valid
//   out_ready       engine accepts the beat
//   busy_o          transfer in progress
//   done_o          one-cycle pulse when the transfer completes
module unpacker #(
   parameter int INPUT_WIDTH = 64,
   parameter int TOTAL_BYTES = 8,
   parameter int BUF_WIDTH   = 128,
   parameter int LEN_WIDTH   = 16
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   start_i,
   input  logic [LEN_WIDTH-1:0]   len_i,
   input  logic [3:0]             lanes_i,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [INPUT_WIDTH-1:0] data_i,
   output logic [INPUT_WIDTH-1:0] data_o,
   output logic [TOTAL_BYTES-1:0] valid_mask,
   output logic                   tlast_o,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic                   busy_o,
   output logic                   done_o
);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t                 state, state_next;
   logic [BUF_WIDTH-1:0]   byte_buf;
   logic [4:0]             buf_count;
   logic [LEN_WIDTH-1:0]   bytes_left;
   logic [LEN_WIDTH-1:0]   fetch_left;
   logic [LEN_WIDTH-1:0]   words_left;
   logic [3:0]             k_lanes;

   logic [3:0]             lanes_clamped;
   logic [3:0]             k_beat;
   logic [3:0]             append;
   logic                   push;
   logic                   pop;
   logic [4:0]             post_count;
   logic [4:0]             count_next;
   logic [BUF_WIDTH-1:0]   incoming;
   logic [BUF_WIDTH-1:0]   buf_next;

   // Low n bytes set, used both to zero the unused tail of a beat and to
   // discard the bytes past the end of the transfer in the final word.
   function automatic logic [INPUT_WIDTH-1:0] byte_mask(input logic [3:0] n);
      logic [INPUT_WIDTH-1:0] m;
      m = '0;
      for (int i = 0; i < TOTAL_BYTES; i++)
         if (i < int'(n)) m[i*8 +: 8] = 8'hFF;
      return m;
   endfunction

   function automatic logic [TOTAL_BYTES-1:0] lane_mask(input logic [3:0] n);
      logic [TOTAL_BYTES-1:0] m;
      m = '0;
      for (int i = 0; i < TOTAL_BYTES; i++)
         if (i < int'(n)) m[i] = 1'b1;
      return m;
   endfunction

   assign in_ready = (state == RUN) && (words_left != '0) && (buf_count <= 5'd8);
   assign busy_o   = (state != IDLE);
   assign done_o   = (state == DONE);

   // Beat sizing, push/pop decisions and the next buffer image. Popped bytes
   // shift out first, then any incoming word lands directly above what is
   // left, so a same-cycle push and pop never overlap.
   always_comb begin
      lanes_clamped = lanes_i;
      if (lanes_i == 4'd0 || lanes_i > 4'd8) lanes_clamped = 4'd8;

      k_beat = k_lanes;
      if (bytes_left < LEN_WIDTH'(k_lanes)) k_beat = bytes_left[3:0];

      append = 4'd8;
      if (fetch_left < LEN_WIDTH'(8)) append = fetch_left[3:0];

      push = in_ready && in_valid;
      pop  = (state == RUN) && (!out_valid || out_ready) &&
             (bytes_left != '0) && (buf_count >= {1'b0, k_beat});

      post_count = buf_count - (pop ? {1'b0, k_beat} : 5'd0);
      count_next = post_count + (push ? {1'b0, append} : 5'd0);

      incoming = {{(BUF_WIDTH-INPUT_WIDTH){1'b0}}, data_i & byte_mask(append)}
                 << {post_count, 3'b000};
      buf_next = pop ? (byte_buf >> {k_beat, 3'b000}) : byte_buf;
      if (push) buf_next = buf_next | incoming;
   end

   // State register.
   always_ff @(posedge clk) begin
      if (!rst) state <= IDLE;
      else      state <= state_next;
   end

   // Next-state logic. A zero-length transfer skips straight to DONE so the
   // caller still gets its completion pulse.
   always_comb begin
      state_next = state;
      case (state)
         IDLE: if (start_i) state_next = (len_i == '0) ? DONE : RUN;
         RUN:  if (out_valid && out_ready && tlast_o) state_next = DONE;
         DONE: state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Datapath: transfer counters, byte buffer and the registered output beat.
   // Outputs only change when a new beat loads or the held beat is taken, so
   // they stay stable while the engine stalls.
   always_ff @(posedge clk) begin
      if (!rst) begin
         byte_buf   <= '0;
         buf_count  <= '0;
         bytes_left <= '0;
         fetch_left <= '0;
         words_left <= '0;
         k_lanes    <= '0;
         data_o     <= '0;
         valid_mask <= '0;
         tlast_o    <= 1'b0;
         out_valid  <= 1'b0;
      end else if (state == IDLE) begin
         if (start_i) begin
            byte_buf   <= '0;
            buf_count  <= '0;
            bytes_left <= len_i;
            fetch_left <= len_i;
            words_left <= (len_i >> 3) + LEN_WIDTH'(len_i[2:0] != 3'd0);
            k_lanes    <= lanes_clamped;
            out_valid  <= 1'b0;
            tlast_o    <= 1'b0;
         end
      end else if (state == RUN) begin
         byte_buf  <= buf_next;
         buf_count <= count_next;
         if (push) begin
            words_left <= words_left - LEN_WIDTH'(1);
            fetch_left <= fetch_left - LEN_WIDTH'(append);
         end
         if (pop) begin
            data_o     <= byte_buf[INPUT_WIDTH-1:0] & byte_mask(k_beat);
            valid_mask <= lane_mask(k_beat);
            tlast_o    <= (bytes_left == LEN_WIDTH'(k_beat));
            out_valid  <= 1'b1;
            bytes_left <= bytes_left - LEN_WIDTH'(k_beat);
         end else if (out_ready) begin
            out_valid <= 1'b0;
         end
      end else begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_unpacker.sv
// tb_unpacker
// Directed testbench for unpacker. Input word j always carries bytes
// 8j..8j+7, so every output beat has a known byte sequence that the bench
// rebuilds from the running byte position.
module tb_unpacker;

   logic        clk = 1'b0;
   logic        rst;
   logic        start_i;
   logic [15:0] len_i;
   logic [3:0]  lanes_i;
   logic        in_valid;
   logic        in_ready;
   logic [63:0] data_i;
   logic [63:0] data_o;
   logic [7:0]  valid_mask;
   logic        tlast_o;
   logic        out_valid;
   logic        out_ready;
   logic        busy_o;
   logic        done_o;

   int checks = 0;
   int errors = 0;

   unpacker dut (
      .clk        (clk),
      .rst        (rst),
      .start_i    (start_i),
      .len_i      (len_i),
      .lanes_i    (lanes_i),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .data_i     (data_i),
      .data_o     (data_o),
      .valid_mask (valid_mask),
      .tlast_o    (tlast_o),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .busy_o     (busy_o),
      .done_o     (done_o)
   );

   always #5 clk = ~clk;

   // Single comparison point: counts every check and reports mismatches.
   task automatic checkOutput(input string tag, input logic [63:0] actual,
                              input logic [63:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s actual=%h expected=%h", tag, actual, expected);
      end
   endtask

   function automatic logic [63:0] word_of(input int j);
      logic [63:0] w;
      for (int b = 0; b < 8; b++) w[b*8 +: 8] = 8'(8*j + b);
      return w;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Runs one transfer: feeds words on demand, drives out_ready from a
   // 4-cycle pattern, checks every accepted beat against the byte model and
   // checks that a stalled beat is held unchanged.
   task automatic applyStimulus(input int len, input logic [3:0] lanes,
                                input logic [3:0] ready_pat, output int cycles);
      int          word_idx, pos, klanes, k, cyc;
      logic        stalled, accepted_in;
      logic [63:0] exp_data, held_data;
      logic [7:0]  exp_mask, held_mask;
      klanes = (lanes == 4'd0 || lanes > 4'd8) ? 8 : int'(lanes);
      start_i = 1'b1;
      len_i   = 16'(len);
      lanes_i = lanes;
      step();
      start_i = 1'b0;
      checkOutput("busy_after_start", busy_o, 1);
      checkOutput("no_beat_before_data", out_valid, 0);
      word_idx = 0; pos = 0; cyc = 0; stalled = 1'b0;
      held_data = '0; held_mask = '0;
      in_valid = 1'b1;
      while (pos < len && cyc < 300) begin
         data_i    = word_of(word_idx);
         out_ready = ready_pat[cyc % 4];
         if (stalled) begin
            checkOutput("stall_valid", out_valid, 1);
            checkOutput("stall_data", data_o, held_data);
            checkOutput("stall_mask", valid_mask, held_mask);
         end
         stalled = 1'b0;
         if (out_valid && out_ready) begin
            k = (len - pos < klanes) ? len - pos : klanes;
            exp_data = '0;
            for (int i = 0; i < k; i++) exp_data[i*8 +: 8] = 8'(pos + i);
            exp_mask = 8'((1 << k) - 1);
            checkOutput("beat_data", data_o, exp_data);
            checkOutput("beat_mask", valid_mask, exp_mask);
            checkOutput("beat_tlast", tlast_o, (pos + k == len));
            pos += k;
         end else if (out_valid) begin
            stalled   = 1'b1;
            held_data = data_o;
            held_mask = valid_mask;
         end
         accepted_in = in_valid && in_ready;
         step();
         cyc++;
         if (accepted_in) word_idx++;
      end
      in_valid  = 1'b0;
      out_ready = 1'b0;
      checkOutput("transfer_complete", 64'(pos >= len), 1);
      checkOutput("done_pulse", done_o, 1);
      checkOutput("valid_after_last", out_valid, 0);
      step();
      checkOutput("done_one_cycle", done_o, 0);
      checkOutput("idle_not_busy", busy_o, 0);
      cycles = cyc;
   endtask

   initial begin
      int cycles;
      int guard;
      rst = 1'b0; start_i = 1'b0; len_i = '0; lanes_i = '0;
      in_valid = 1'b0; data_i = '0; out_ready = 1'b0;
      repeat (3) step();
      checkOutput("reset_valid", out_valid, 0);
      checkOutput("reset_data", data_o, 0);
      checkOutput("reset_mask", valid_mask, 0);
      checkOutput("reset_busy", busy_o, 0);
      checkOutput("reset_in_ready", in_ready, 0);
      rst = 1'b1;
      step();

      $display("[TB] len=16 lanes=8");
      applyStimulus(16, 4'd8, 4'b1111, cycles);
      checkOutput("full_rate_cycles", cycles, 4);

      $display("[TB] len=10 lanes=4");
      applyStimulus(10, 4'd4, 4'b1111, cycles);

      $display("[TB] len=24 lanes=3 with stalls");
      applyStimulus(24, 4'd3, 4'b1001, cycles);

      $display("[TB] len=0");
      in_valid = 1'b1;
      data_i   = word_of(0);
      start_i  = 1'b1; len_i = 16'd0; lanes_i = 4'd8;
      step();
      start_i = 1'b0;
      checkOutput("zero_done", done_o, 1);
      checkOutput("zero_in_ready", in_ready, 0);
      checkOutput("zero_valid", out_valid, 0);
      step();
      checkOutput("zero_done_clear", done_o, 0);
      checkOutput("zero_idle_in_ready", in_ready, 0);
      checkOutput("zero_idle_busy", busy_o, 0);
      in_valid = 1'b0;

      $display("[TB] lanes clamping");
      applyStimulus(8, 4'd0, 4'b1111, cycles);
      applyStimulus(8, 4'd12, 4'b1111, cycles);

      $display("[TB] reset mid-transfer");
      start_i = 1'b1; len_i = 16'd24; lanes_i = 4'd8;
      step();
      start_i   = 1'b0;
      in_valid  = 1'b1;
      out_ready = 1'b1;
      guard = 0;
      data_i = word_of(0);
      while (!out_valid && guard < 20) begin
         data_i = word_of(guard == 0 ? 0 : 1);
         step();
         guard++;
      end
      checkOutput("abort_first_beat_seen", out_valid, 1);
      step();
      rst = 1'b0;
      step();
      checkOutput("abort_valid", out_valid, 0);
      checkOutput("abort_data", data_o, 0);
      checkOutput("abort_mask", valid_mask, 0);
      checkOutput("abort_tlast", tlast_o, 0);
      checkOutput("abort_done", done_o, 0);
      checkOutput("abort_busy", busy_o, 0);
      rst = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      step();
      checkOutput("abort_no_late_done", done_o, 0);
      applyStimulus(24, 4'd8, 4'b1111, cycles);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
